alu_pipe: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU (a_i, b_i, op_i, res_o).
- Adds a clock, valid/ready handshakes on input and output, status flags, and a multi-cycle shift-add multiply on the previously unused opcode 7.
- Sits between an operand source (sequencer or register file) and a result consumer that may apply backpressure.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // flags_o = {zero, negative, carry, overflow}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// done is a combinational pulse during the final step and prod carries the
// value the accumulator takes on that step, so the owner can latch it on the
// same edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CW'(1));
  assign prod    = acc_nxt;

  // Load operands on start, then add-and-shift once per cycle until count hits zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle
// multiply on opcode 7. One operation in flight at a time; a result handoff
// and a new acceptance can share an edge, giving one result per cycle for
// single-cycle ops.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);

  state_t               state;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  assign in_ready_o  = rst_ni && ((state == ST_IDLE) || (state == ST_DONE && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign mul_start   = accept && (op_i == OP_MUL);
  assign out_valid_o = (state == ST_DONE);
  assign busy_o      = (state == ST_BUSY);

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHW-1:0];

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[WIDTH-1];
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

  // Single-cycle datapath for ops 0-6; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SHL:  alu_res = a_i << shamt;
      OP_SHR:  alu_res = a_i >> shamt;
      default: alu_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start  (mul_start),
    .a      (a_i),
    .b      (b_i),
    .done   (mul_done),
    .prod   (mul_prod)
  );

  // Control FSM with registered result/flags; a new acceptance takes priority
  // over a plain handoff so DONE can chain straight into the next op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      res_o   <= '0;
      flags_o <= '0;
    end else if (accept) begin
      if (op_i == OP_MUL) begin
        state <= ST_BUSY;
      end else begin
        state   <= ST_DONE;
        res_o   <= alu_res;
        flags_o <= mk_flags(alu_res, alu_c, alu_v);
      end
    end else if (state == ST_BUSY && mul_done) begin
      state   <= ST_DONE;
      res_o   <= mul_prod[WIDTH-1:0];
      flags_o <= mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
    end else if (state == ST_DONE && out_ready_i) begin
      state <= ST_IDLE;
    end
  end

endmodule
